// File: rtl/sram_bridge.sv
// sram_bridge: 32-bit req/ready/done load/store port onto a 16-bit async SRAM,
// issued as up to two halfword beats with SETUP/ACCESS/HOLD strobe timing.
module sram_bridge #(
  parameter int ADDR_W   = 18,
  parameter int WAIT_CYC = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req,
  output logic              o_ready,
  input  logic              i_we,
  input  logic [31:0]       i_addr,
  input  logic [3:0]        i_be,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_sram_addr,
  inout  wire  [15:0]       io_sram_dq,
  output logic              o_sram_ce_n,
  output logic              o_sram_we_n,
  output logic              o_sram_oe_n,
  output logic              o_sram_lb_n,
  output logic              o_sram_ub_n
);
  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, HOLD, DONE} state_t;
  localparam logic [2:0] LAST = 3'(WAIT_CYC);
  state_t state_q, state_d;
  logic beat_q, beat_d;
  logic [2:0] cnt_q, cnt_d;
  logic we_q, we_d;
  logic [ADDR_W-2:0] waddr_q, waddr_d;
  logic [3:0] be_q, be_d;
  logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic ready_q, ready_d, done_q, done_d;
  logic [ADDR_W-1:0] sa_q, sa_d;
  logic ce_n_q, ce_n_d, we_n_q, we_n_d, oe_n_q, oe_n_d;
  logic lb_n_q, lb_n_d, ub_n_q, ub_n_d, dq_oe_q, dq_oe_d;
  logic [15:0] dq_q, dq_d, rd_hw;
  logic [1:0] cur_lanes, nxt_lanes;
  logic busy;
  logic unused_addr;
  assign unused_addr = ^{i_addr[31:ADDR_W+1], i_addr[1:0]};
  always_comb begin
    state_d = state_q;
    beat_d = beat_q;
    cnt_d = cnt_q;
    we_d = we_q;
    waddr_d = waddr_q;
    be_d = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cur_lanes = beat_q ? be_q[3:2] : be_q[1:0];
    rd_hw = io_sram_dq & {{8{cur_lanes[1]}}, {8{cur_lanes[0]}}};
    case (state_q)
      IDLE: if (i_req && ready_q) begin
        we_d = i_we;
        waddr_d = i_addr[ADDR_W:2];
        be_d = i_be;
        wdata_d = i_wdata;
        rdata_d = '0;
        beat_d = ~|i_be[1:0];
        state_d = |i_be ? SETUP : DONE;
      end
      SETUP: begin
        state_d = ACCESS;
        cnt_d = '0;
      end
      ACCESS: if (cnt_q == LAST) begin
        state_d = HOLD;
        if (!we_q) rdata_d = beat_q ? {rd_hw, rdata_q[15:0]} : {rdata_q[31:16], rd_hw};
      end else cnt_d = cnt_q + 3'd1;
      HOLD: begin
        state_d = (!beat_q && |be_q[3:2]) ? SETUP : DONE;
        beat_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // Strobes are decoded from the next state so they leave flops glitch-free.
    busy = state_d inside {SETUP, ACCESS, HOLD};
    nxt_lanes = beat_d ? be_d[3:2] : be_d[1:0];
    sa_d = busy ? {waddr_d, beat_d} : sa_q;
    ce_n_d = ~busy;
    lb_n_d = ~(busy && nxt_lanes[0]);
    ub_n_d = ~(busy && nxt_lanes[1]);
    we_n_d = ~(state_d == ACCESS && we_d);
    oe_n_d = ~(state_d == ACCESS && !we_d);
    dq_oe_d = we_d && (state_d == ACCESS || state_d == HOLD);
    dq_d = beat_d ? wdata_d[31:16] : wdata_d[15:0];
    ready_d = state_d == IDLE;
    done_d = state_d == DONE;
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state_q <= IDLE;
      beat_q <= 1'b0;
      cnt_q <= '0;
      we_q <= 1'b0;
      waddr_q <= '0;
      be_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b1;
      done_q <= 1'b0;
      sa_q <= '0;
      ce_n_q <= 1'b1;
      we_n_q <= 1'b1;
      oe_n_q <= 1'b1;
      lb_n_q <= 1'b1;
      ub_n_q <= 1'b1;
      dq_oe_q <= 1'b0;
      dq_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q <= beat_d;
      cnt_q <= cnt_d;
      we_q <= we_d;
      waddr_q <= waddr_d;
      be_q <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      done_q <= done_d;
      sa_q <= sa_d;
      ce_n_q <= ce_n_d;
      we_n_q <= we_n_d;
      oe_n_q <= oe_n_d;
      lb_n_q <= lb_n_d;
      ub_n_q <= ub_n_d;
      dq_oe_q <= dq_oe_d;
      dq_q <= dq_d;
    end
  assign io_sram_dq = dq_oe_q ? dq_q : 16'bz;
  assign o_ready = ready_q;
  assign o_done = done_q;
  assign o_rdata = rdata_q;
  assign o_sram_addr = sa_q;
  assign o_sram_ce_n = ce_n_q;
  assign o_sram_we_n = we_n_q;
  assign o_sram_oe_n = oe_n_q;
  assign o_sram_lb_n = lb_n_q;
  assign o_sram_ub_n = ub_n_q;
endmodule

// File: tb/tb_sram_bridge.sv
// tb_sram_bridge: vector table plus scoreboard for sram_bridge, with async SRAM models.
module tb_sram_bridge;
  localparam int AW = 18;
  typedef struct {
    logic w; logic [31:0] a; logic [3:0] b; logic [31:0] wd; logic [31:0] rd;
    int cyc; int wec; int cec; logic [AW-1:0] fa; logic [7:0] mi; logic [15:0] mv;
  } vec_t;
  typedef struct { logic [31:0] rd; int cyc; } exp_t;
  logic clk = 0, rst_n = 0, req = 0, req0 = 0, we = 0;
  logic [31:0] addr = 0, wdata = 0;
  logic [3:0] be = 0;
  logic ready, done, ce_n, we_n, oe_n, lb_n, ub_n;
  logic ready0, done0, ce0_n, we0_n, oe0_n, lb0_n, ub0_n;
  logic [31:0] rdata, rdata0;
  logic [AW-1:0] sa, sa0;
  wire [15:0] dq, dq0;
  logic [15:0] mem [256];
  logic [15:0] mem0 [256];
  logic pl_en = 0;
  logic [7:0] pl_a = 0;
  logic [15:0] pl_d = 0;
  int checks = 0, failures = 0;
  exp_t sb[$];
  vec_t v[12];

  sram_bridge #(.ADDR_W(AW), .WAIT_CYC(1)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .o_ready(ready), .i_we(we), .i_addr(addr),
    .i_be(be), .i_wdata(wdata), .o_rdata(rdata), .o_done(done), .o_sram_addr(sa),
    .io_sram_dq(dq), .o_sram_ce_n(ce_n), .o_sram_we_n(we_n), .o_sram_oe_n(oe_n),
    .o_sram_lb_n(lb_n), .o_sram_ub_n(ub_n));
  sram_bridge #(.ADDR_W(AW), .WAIT_CYC(0)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req0), .o_ready(ready0), .i_we(we), .i_addr(addr),
    .i_be(be), .i_wdata(wdata), .o_rdata(rdata0), .o_done(done0), .o_sram_addr(sa0),
    .io_sram_dq(dq0), .o_sram_ce_n(ce0_n), .o_sram_we_n(we0_n), .o_sram_oe_n(oe0_n),
    .o_sram_lb_n(lb0_n), .o_sram_ub_n(ub0_n));

  always #5 clk = ~clk;
  assign dq = (!ce_n && !oe_n && we_n) ? mem[sa[7:0]] : 16'bz;
  assign dq0 = (!ce0_n && !oe0_n && we0_n) ? mem0[sa0[7:0]] : 16'bz;
  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_a] <= pl_d;
      mem0[pl_a] <= pl_d;
    end
    if (!ce_n && !we_n) begin
      if (!lb_n) mem[sa[7:0]][7:0] <= dq[7:0];
      if (!ub_n) mem[sa[7:0]][15:8] <= dq[15:8];
    end
    if (!ce0_n && !we0_n) begin
      if (!lb0_n) mem0[sa0[7:0]][7:0] <= dq0[7:0];
      if (!ub0_n) mem0[sa0[7:0]][15:8] <= dq0[15:8];
    end
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [15:0] d);
    @(negedge clk);
    pl_en = 1; pl_a = a; pl_d = d;
    @(negedge clk);
    pl_en = 0;
  endtask

  task automatic run(input vec_t t);
    int dc = 0, wec = 0, cec = 0, rdy = 0;
    logic [AW-1:0] fa = '0;
    bit ga = 0;
    exp_t e;
    chk("ready_before", 32'(ready), 1);
    we = t.w; addr = t.a; be = t.b; wdata = t.wd; req = 1;
    sb.push_back('{t.rd, t.cyc});
    @(posedge clk);
    for (int c = 1; c <= 40 && dc == 0; c++) begin
      @(negedge clk);
      req = 0;
      if (!we_n) wec++;
      if (!ce_n) begin
        cec++;
        if (!ga) begin ga = 1; fa = sa; end
      end
      if (done) dc = c;
      else if (ready) rdy++;
    end
    e = sb.pop_front();
    chk("done_seen", 32'(dc != 0), 1);
    chk("done_cycle", dc, e.cyc);
    chk("rdata", rdata, e.rd);
    chk("ready_low_busy", rdy, 0);
    chk("we_low_cycles", wec, t.wec);
    chk("ce_low_cycles", cec, t.cec);
    if (t.cec > 0) chk("first_addr", 32'(fa), 32'(t.fa));
    chk("mem", 32'(mem[t.mi]), 32'(t.mv));
    @(negedge clk);
    chk("ready_after", 32'(ready), 1);
    chk("done_pulse", 32'(done), 0);
    chk("rdata_hold", rdata, e.rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int nd, rhi, r8;
    exp_t e;
    v[0]  = '{1'b0, 32'h8,        4'hF, 32'h0,        32'h56781234, 9, 0, 8, 18'd4, 8'd4, 16'h1234};
    v[1]  = '{1'b0, 32'h8,        4'h3, 32'h0,        32'h00001234, 5, 0, 4, 18'd4, 8'd5, 16'h5678};
    v[2]  = '{1'b0, 32'h8,        4'h8, 32'h0,        32'h56000000, 5, 0, 4, 18'd5, 8'd4, 16'h1234};
    v[3]  = '{1'b0, 32'h8,        4'h6, 32'h0,        32'h00781200, 9, 0, 8, 18'd4, 8'd5, 16'h5678};
    v[4]  = '{1'b0, 32'h00100008, 4'hF, 32'h0,        32'h56781234, 9, 0, 8, 18'd4, 8'd4, 16'h1234};
    v[5]  = '{1'b1, 32'h8,        4'hF, 32'hDEADBEEF, 32'h0,        9, 4, 8, 18'd4, 8'd4, 16'hBEEF};
    v[6]  = '{1'b1, 32'h8,        4'h4, 32'h00AA0000, 32'h0,        5, 2, 4, 18'd5, 8'd5, 16'hDEAA};
    v[7]  = '{1'b1, 32'h8,        4'h0, 32'hFFFFFFFF, 32'h0,        1, 0, 0, 18'd0, 8'd5, 16'hDEAA};
    v[8]  = '{1'b0, 32'h8,        4'h0, 32'h0,        32'h0,        1, 0, 0, 18'd0, 8'd4, 16'hBEEF};
    v[9]  = '{1'b0, 32'h8,        4'hF, 32'h0,        32'hDEAABEEF, 9, 0, 8, 18'd4, 8'd5, 16'hDEAA};
    v[10] = '{1'b1, 32'hC,        4'h9, 32'h11223344, 32'h0,        9, 4, 8, 18'd6, 8'd7, 16'h1100};
    v[11] = '{1'b0, 32'hC,        4'hF, 32'h0,        32'h11000044, 9, 0, 8, 18'd6, 8'd6, 16'h0044};
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(ready), 1);
    chk("rst_done", 32'(done), 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_addr", 32'(sa), 0);
    chk("rst_strobes", 32'({ce_n, we_n, oe_n, lb_n, ub_n}), 32'h1F);
    chk("rst_ready0", 32'(ready0), 1);
    preload(8'd4, 16'h1234);
    preload(8'd5, 16'h5678);
    preload(8'd6, 16'h0000);
    preload(8'd7, 16'h0000);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    for (int i = 0; i < 12; i++) run(v[i]);
    we = 1; addr = 32'h8; be = 4'hF; wdata = 32'hCAFEF00D; req = 1;
    @(posedge clk);
    repeat (6) begin @(negedge clk); req = 0; end
    chk("mid_we_active", 32'(we_n), 0);
    chk("mid_beat1_addr", 32'(sa), 5);
    rst_n = 0;
    #1;
    chk("mid_rst_we_n", 32'(we_n), 1);
    chk("mid_rst_ce_n", 32'(ce_n), 1);
    chk("mid_rst_ready", 32'(ready), 1);
    chk("mid_rst_done", 32'(done), 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    nd = 0;
    repeat (15) begin @(negedge clk); if (done) nd++; end
    chk("mid_no_done", nd, 0);
    chk("mid_ready_after", 32'(ready), 1);
    chk("mid_rdata", rdata, 0);
    chk("mid_beat0_written", 32'(mem[4]), 32'h0000F00D);
    chk("mid_beat1_dropped", 32'(mem[5]), 32'h0000DEAA);
    we = 0; addr = 32'h8; be = 4'hF; req0 = 1;
    sb.push_back('{32'h56781234, 7});
    sb.push_back('{32'h56781234, 15});
    rhi = 0; r8 = 0;
    @(posedge clk);
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c == 9) req0 = 0;
      if (c <= 15 && ready0) rhi++;
      if (c == 8) r8 = 32'(ready0);
      if (done0) begin
        if (sb.size() == 0) chk("b2b_extra_done", c, 0);
        else begin
          e = sb.pop_front();
          chk("b2b_done_cycle", c, e.cyc);
          chk("b2b_rdata", rdata0, e.rd);
        end
      end
    end
    chk("b2b_missing_done", sb.size(), 0);
    chk("b2b_ready_cycle8", r8, 1);
    chk("b2b_ready_high_count", rhi, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
